// File: rtl/cache_miss_handler_pkg.sv
// Shared definitions for the load-miss handler: opcodes, FSM encoding,
// the queued miss entry and the load-result formatter.
package cache_miss_handler_pkg;

    localparam logic [3:0] OP_LB = 4'd7;
    localparam logic [3:0] OP_LW = 4'd8;
    localparam logic [3:0] OP_SB = 4'd9;
    localparam logic [3:0] OP_SW = 4'd10;

    localparam int CMH_ADDR_W = 32;
    localparam int CMH_REG_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } cmh_state_e;

    typedef struct packed {
        logic [3:0]            optype;
        logic [CMH_ADDR_W-1:0] addr;
        logic [CMH_REG_W-1:0]  rtag;
        logic [31:0]           pc;
    } miss_entry_t;

    function automatic logic is_load_op(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LW);
    endfunction

    // LB returns byte 0 of the word, mirroring the cache hit path.
    function automatic logic [31:0] format_load(input logic [3:0] op, input logic [31:0] word);
        logic [31:0] res;
        case (op)
            OP_LB:   res = {24'h00_0000, word[7:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cache_miss_handler_miss_fifo.sv
// Synchronous FIFO holding pending load misses; flush empties it in one edge
// and overrides any push or pop in that cycle.
module miss_fifo #(
    parameter  int W     = 74,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [PW:0]  count
);

    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full && !flush;
    assign pop_ok_s  = pop && !empty && !flush;

    // Storage write; entries need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1'b1);
                2'b01:   count_r <= count_r - (PW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cache_miss_handler.sv
// Queues data-cache load misses, fetches each word from memory one request
// at a time, and returns the refill plus the formatted load result in order.
module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [3:0]        miss_optype,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [REG_W-1:0]  miss_reg,
    input  logic [31:0]       miss_pc,
    output logic              miss_ready,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [31:0]       fill_data,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_reg,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_data
);

    localparam int QPW = $clog2(QDEPTH);
    localparam logic [QPW:0]      QDEPTH_C  = QDEPTH[QPW:0];
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(2'b11);

    cmh_state_e        state_r;
    cmh_state_e        state_s;
    miss_entry_t       act_r;
    logic              squash_r;
    logic [31:0]       data_r;

    miss_entry_t       entry_s;
    miss_entry_t       fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [QPW:0]      fifo_count_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] word_addr_s;

    assign entry_s.optype = miss_optype;
    assign entry_s.addr   = CMH_ADDR_W'(miss_addr);
    assign entry_s.rtag   = CMH_REG_W'(miss_reg);
    assign entry_s.pc     = miss_pc;

    assign miss_ready = (fifo_count_s < QDEPTH_C);
    assign push_s     = miss_valid && !fifo_full_s && is_load_op(miss_optype) && !flush;
    assign pop_s      = (state_r == ST_IDLE) && !fifo_empty_s && !flush;

    miss_fifo #(
        .W     ($bits(miss_entry_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (entry_s),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .flush     (flush),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Next-state logic for the single outstanding memory transaction.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) state_s = ST_REQ;
                else       state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_req_ready) state_s = ST_WAIT;
                else               state_s = ST_REQ;
            end
            ST_WAIT: begin
                if (mem_resp_valid) state_s = ST_DONE;
                else                state_s = ST_WAIT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, active entry, squash flag and returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            act_r    <= '0;
            squash_r <= 1'b0;
            data_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            if (pop_s) begin
                act_r    <= fifo_head_s;
                squash_r <= 1'b0;
            end else if (flush && ((state_r == ST_REQ) || (state_r == ST_WAIT))) begin
                // A squashed fetch still finishes its handshake so memory stays in step.
                squash_r <= 1'b1;
            end
            if ((state_r == ST_WAIT) && mem_resp_valid) begin
                data_r <= mem_resp_data;
            end
        end
    end

    assign word_addr_s   = act_r.addr[ADDR_W-1:0] & WORD_MASK;
    assign mem_req_valid = (state_r == ST_REQ);
    assign mem_req_addr  = word_addr_s;
    assign fill_valid    = (state_r == ST_DONE);
    assign fill_addr     = word_addr_s;
    assign fill_data     = data_r;
    // A flush arriving in DONE still has to kill the writeback.
    assign wb_valid      = (state_r == ST_DONE) && !squash_r && !flush;
    assign wb_reg        = act_r.rtag[REG_W-1:0];
    assign wb_pc         = act_r.pc;
    assign wb_data       = format_load(act_r.optype, data_r);

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: a scoreboard of accepted misses is
// matched against memory requests, refills and writebacks as they appear.
module tb_cache_miss_handler;
    import cache_miss_handler_pkg::*;

    typedef struct {
        logic [31:0] waddr;
        logic [5:0]  rtag;
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] wb;
        bit          sq;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [3:0]  miss_optype;
    logic [31:0] miss_addr;
    logic [5:0]  miss_reg;
    logic [31:0] miss_pc;
    logic        miss_ready;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        wb_valid;
    logic [5:0]  wb_reg;
    logic [31:0] wb_pc;
    logic [31:0] wb_data;

    exp_t q_pend[$];
    exp_t q_out[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_lat = 0;
    bit   resp_en = 1'b1;
    logic [31:0] pend_addr = 32'h0;

    cache_miss_handler dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_optype(miss_optype), .miss_addr(miss_addr),
        .miss_reg(miss_reg), .miss_pc(miss_pc), .miss_ready(miss_ready),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_pc(wb_pc), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_model(input logic [31:0] wa);
        case (wa)
            32'h0000_1004: return 32'hDEAD_BEEF;
            32'h0000_2000: return 32'h1234_5678;
            32'h0000_4000: return 32'hAAAA_5555;
            default:       return {wa[15:0] ^ 16'h5A5A, wa[15:0]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: handshake bookkeeping before the edge, responder and output checks after.
    task automatic tick();
        bit          hs;
        logic [31:0] ha;
        exp_t        e;
        hs = mem_req_valid && mem_req_ready;
        ha = mem_req_addr;
        if (hs) begin
            chkb("req_expected", q_pend.size() != 0, 1'b1);
            if (q_pend.size() != 0) begin
                e = q_pend.pop_front();
                chk("req_addr", ha, e.waddr);
                q_out.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (hs) pend_addr = ha;
        mem_resp_valid = hs && resp_en;
        mem_resp_data  = (hs && resp_en) ? mem_model(ha) : 32'h0;
        if (fill_valid) begin
            chkb("fill_expected", q_out.size() != 0, 1'b1);
            if (q_out.size() != 0) begin
                e = q_out.pop_front();
                chk("fill_addr", fill_addr, e.waddr);
                chk("fill_data", fill_data, e.word);
                chkb("wb_valid", wb_valid, !e.sq);
                if (!e.sq) begin
                    chk("wb_reg", 32'(wb_reg), 32'(e.rtag));
                    chk("wb_pc", wb_pc, e.pc);
                    chk("wb_data", wb_data, e.wb);
                end
                last_lat = cyc - e.acc + 1;
            end
        end else begin
            chkb("wb_without_fill", wb_valid, 1'b0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic miss(input logic [3:0] op, input logic [31:0] a, input logic [5:0] r,
                        input logic [31:0] pc, input logic exp_rdy);
        exp_t e;
        miss_valid  = 1'b1;
        miss_optype = op;
        miss_addr   = a;
        miss_reg    = r;
        miss_pc     = pc;
        chkb("miss_ready", miss_ready, exp_rdy);
        if (exp_rdy && (op == OP_LB || op == OP_LW) && !flush) begin
            e.waddr = {a[31:2], 2'b00};
            e.rtag  = r;
            e.pc    = pc;
            e.word  = mem_model(e.waddr);
            e.wb    = (op == OP_LB) ? {24'h00_0000, e.word[7:0]} : e.word;
            e.sq    = 1'b0;
            e.acc   = cyc + 1;
            q_pend.push_back(e);
        end
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((q_pend.size() != 0 || q_out.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chkb("drain_in_time", (q_pend.size() == 0 && q_out.size() == 0), 1'b1);
    endtask

    task automatic chk_quiet(input string tag);
        chkb({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
        chkb({tag, "_fill_valid"}, fill_valid, 1'b0);
        chkb({tag, "_wb_valid"}, wb_valid, 1'b0);
        chk({tag, "_mem_req_addr"}, mem_req_addr, 32'h0);
        chk({tag, "_fill_addr"}, fill_addr, 32'h0);
        chk({tag, "_fill_data"}, fill_data, 32'h0);
        chk({tag, "_wb_reg"}, 32'(wb_reg), 32'h0);
        chk({tag, "_wb_pc"}, wb_pc, 32'h0);
        chk({tag, "_wb_data"}, wb_data, 32'h0);
        chkb({tag, "_miss_ready"}, miss_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; miss_valid = 1'b0; miss_optype = 4'd0; miss_addr = 32'h0;
        miss_reg = 6'd0; miss_pc = 32'h0; flush = 1'b0; mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        run(2);
        chk_quiet("reset");
        rst = 1'b0;
        tick();

        // 1: LW with zero-wait memory, latency from accepting edge
        miss(OP_LW, 32'h0000_1004, 6'd5, 32'h0000_0100, 1'b1);
        drain(20);
        chk("lw_latency", 32'(last_lat), 32'd4);

        // 2: LB returns byte 0, refill is the full word
        miss(OP_LB, 32'h0000_2003, 6'd7, 32'h0000_0104, 1'b1);
        drain(20);

        // 3: memory stalled; active entry plus four queued fills the queue
        mem_req_ready = 1'b0;
        miss(OP_LW, 32'h0000_3000, 6'd1, 32'h0000_0200, 1'b1);
        run(2);
        chkb("stall_req_valid", mem_req_valid, 1'b1);
        miss(OP_LW, 32'h0000_3010, 6'd2, 32'h0000_0204, 1'b1);
        miss(OP_LW, 32'h0000_3020, 6'd3, 32'h0000_0208, 1'b1);
        miss(OP_LW, 32'h0000_3030, 6'd4, 32'h0000_020C, 1'b1);
        miss(OP_LW, 32'h0000_3040, 6'd6, 32'h0000_0210, 1'b1);
        miss(OP_LW, 32'h0000_3050, 6'd8, 32'h0000_0214, 1'b0);
        chkb("full_ready_low", miss_ready, 1'b0);
        mem_req_ready = 1'b1;
        drain(80);
        run(3);
        chkb("after_drain_ready", miss_ready, 1'b1);

        // 4: flush with one entry in WAIT and two queued
        resp_en = 1'b0;
        miss(OP_LW, 32'h0000_4000, 6'd9, 32'h0000_0300, 1'b1);
        miss(OP_LW, 32'h0000_4100, 6'd10, 32'h0000_0304, 1'b1);
        miss(OP_LW, 32'h0000_4200, 6'd11, 32'h0000_0308, 1'b1);
        chk("flush_in_wait", 32'(q_out.size()), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        // the active entry stays in q_out but loses its writeback
        q_pend.delete();
        foreach (q_out[i]) q_out[i].sq = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_model(pend_addr);
        tick();
        run(3);
        chk("flush_fill_done", 32'(q_out.size()), 32'd0);
        chkb("flush_no_req", mem_req_valid, 1'b0);
        chkb("flush_fifo_empty", dut.fifo_empty_s, 1'b1);
        chk("flush_state", 32'(dut.state_r), 32'(ST_IDLE));
        resp_en = 1'b1;

        // 5: stores are dropped
        miss(OP_SW, 32'h0000_5000, 6'd12, 32'h0000_0400, 1'b1);
        miss(OP_SB, 32'h0000_5004, 6'd13, 32'h0000_0404, 1'b1);
        run(3);
        chkb("store_no_req", mem_req_valid, 1'b0);
        chkb("store_ready", miss_ready, 1'b1);

        // 6: reset while in WAIT, then a stray response
        resp_en = 1'b0;
        miss(OP_LW, 32'h0000_6000, 6'd14, 32'h0000_0500, 1'b1);
        run(2);
        chk("rst_in_wait", 32'(q_out.size()), 32'd1);
        rst = 1'b1;
        tick();
        q_pend.delete();
        q_out.delete();
        chk_quiet("rst_mid");
        rst = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hCAFE_F00D;
        tick();
        run(3);
        chk_quiet("rst_stray");
        chk("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        resp_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
